// File: rtl/qbus_dma_arbiter_pkg.sv
// Shared definitions for the QBUS DMA arbiter: state encodings, default
// timing constants and the timer sizing helper.
`timescale 1ns/1ps
package qbus_dma_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE   = 2'd0;
   localparam logic [1:0] ARB_GRANT  = 2'd1;
   localparam logic [1:0] ARB_MASTER = 2'd2;
   localparam logic [1:0] ARB_GAP    = 2'd3;

   localparam int DEFAULT_GRANT_TIMEOUT = 200;
   localparam int DEFAULT_CPU_GAP       = 4;
   localparam int DEFAULT_COUNT_W       = 16;

   // The timer counts 0..max-1, so it needs clog2(max) bits (at least one).
   function automatic int timer_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 2) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/qbus_dma_arbiter_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous bus inputs.
`timescale 1ns/1ps
module qbus_dma_arbiter_sync2
   import qbus_dma_arbiter_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk20,
   input  logic             reset_L,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         always_ff @(posedge clk20) begin
            if (!reset_L) begin
               meta_reg[gi] <= 1'b0;
               sync_reg[gi] <= 1'b0;
            end else begin
               meta_reg[gi] <= din[gi];
               sync_reg[gi] <= meta_reg[gi];
            end
         end
      end
   endgenerate

   assign dout = sync_reg;

endmodule

// File: rtl/qbus_dma_arbiter.sv
// QBUS DMA bus arbiter: answers DMR with a DMG grant, waits out the SACK
// tenure, times out unacknowledged grants and keeps grant statistics.
`timescale 1ns/1ps
module qbus_dma_arbiter
   import qbus_dma_arbiter_pkg::*;
#(
   parameter int GRANT_TIMEOUT = DEFAULT_GRANT_TIMEOUT,
   parameter int CPU_GAP       = DEFAULT_CPU_GAP,
   parameter int COUNT_W       = DEFAULT_COUNT_W
) (
   input  logic               clk20,
   input  logic               reset_L,
   input  logic               RINIT,
   input  logic               RDMR,
   input  logic               RSACK,
   input  logic               cpu_busy,
   output logic               TDMGO,
   output logic               dma_tenure,
   output logic               timeout_pulse,
   output logic [COUNT_W-1:0] grant_count,
   output logic [COUNT_W-1:0] timeout_count
);

   localparam int TIMER_W = timer_width(GRANT_TIMEOUT, CPU_GAP);
   localparam logic [TIMER_W-1:0] GRANT_LAST = TIMER_W'(GRANT_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'((CPU_GAP > 0) ? CPU_GAP - 1 : 0);
   // With no gap configured a finished tenure returns straight to IDLE.
   localparam logic [1:0] ARB_AFTER = (CPU_GAP == 0) ? ARB_IDLE : ARB_GAP;

   logic [2:0] sync_out;
   logic       s_dmr;
   logic       s_sack;
   logic       s_init;

   logic [1:0]         state_reg, state_next;
   logic [TIMER_W-1:0] timer_reg, timer_next;
   logic               timeout_pulse_reg;
   logic [COUNT_W-1:0] grant_count_reg;
   logic [COUNT_W-1:0] timeout_count_reg;
   logic               grant_inc;
   logic               timeout_inc;

   qbus_dma_arbiter_sync2 #(.WIDTH(3)) u_sync (
      .clk20   (clk20),
      .reset_L (reset_L),
      .din     ({RINIT, RSACK, RDMR}),
      .dout    (sync_out)
   );

   assign s_dmr  = sync_out[0];
   assign s_sack = sync_out[1];
   assign s_init = sync_out[2];

   always_comb begin
      state_next  = state_reg;
      timer_next  = timer_reg;
      grant_inc   = 1'b0;
      timeout_inc = 1'b0;
      case (state_reg)
         ARB_IDLE: begin
            // A high sSACK here belongs to another arbiter's tenure.
            if (s_dmr && !s_sack && !cpu_busy) begin
               state_next = ARB_GRANT;
               timer_next = '0;
            end
         end
         ARB_GRANT: begin
            if (s_sack) begin
               state_next = ARB_MASTER;
               grant_inc  = 1'b1;
            end else if (timer_reg == GRANT_LAST) begin
               state_next  = ARB_AFTER;
               timer_next  = '0;
               timeout_inc = 1'b1;
            end else begin
               timer_next = timer_reg + TIMER_W'(1);
            end
         end
         ARB_MASTER: begin
            if (!s_sack) begin
               state_next = ARB_AFTER;
               timer_next = '0;
            end
         end
         ARB_GAP: begin
            if (timer_reg == GAP_LAST) begin
               state_next = ARB_IDLE;
               timer_next = '0;
            end else begin
               timer_next = timer_reg + TIMER_W'(1);
            end
         end
         default: begin
            state_next = ARB_IDLE;
            timer_next = '0;
         end
      endcase
   end

   // Counters are only written on an event so their value otherwise holds.
   always_ff @(posedge clk20) begin
      if (!reset_L || s_init) begin
         state_reg         <= ARB_IDLE;
         timer_reg         <= '0;
         timeout_pulse_reg <= 1'b0;
         grant_count_reg   <= '0;
         timeout_count_reg <= '0;
      end else begin
         state_reg         <= state_next;
         timer_reg         <= timer_next;
         timeout_pulse_reg <= timeout_inc;
         if (grant_inc)
            grant_count_reg <= grant_count_reg + COUNT_W'(1);
         if (timeout_inc)
            timeout_count_reg <= timeout_count_reg + COUNT_W'(1);
      end
   end

   assign TDMGO         = (state_reg == ARB_GRANT);
   assign dma_tenure    = (state_reg == ARB_GRANT) || (state_reg == ARB_MASTER);
   assign timeout_pulse = timeout_pulse_reg;
   assign grant_count   = grant_count_reg;
   assign timeout_count = timeout_count_reg;

endmodule

// File: tb/tb_qbus_dma_arbiter.sv
// Directed bench for qbus_dma_arbiter: grant, timeout, cpu_busy, SACK race,
// reset mid-tenure and counter wrap.
`timescale 1ns/1ps
module tb_qbus_dma_arbiter;
   import qbus_dma_arbiter_pkg::*;

   logic        clk20 = 1'b0;
   logic        reset_L;
   logic        RINIT;
   logic        RDMR;
   logic        RSACK;
   logic        cpu_busy;
   logic        TDMGO;
   logic        dma_tenure;
   logic        timeout_pulse;
   logic [15:0] grant_count;
   logic [15:0] timeout_count;

   int n_cmp = 0;
   int n_err = 0;

   qbus_dma_arbiter dut (
      .clk20         (clk20),
      .reset_L       (reset_L),
      .RINIT         (RINIT),
      .RDMR          (RDMR),
      .RSACK         (RSACK),
      .cpu_busy      (cpu_busy),
      .TDMGO         (TDMGO),
      .dma_tenure    (dma_tenure),
      .timeout_pulse (timeout_pulse),
      .grant_count   (grant_count),
      .timeout_count (timeout_count)
   );

   always #25 clk20 = ~clk20;

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk20);
      #1;
   endtask

   task automatic test_reset;
      reset_L = 1'b0; RINIT = 1'b0; RDMR = 1'b0; RSACK = 1'b0; cpu_busy = 1'b0;
      tick(2);
      n_cmp++; if (TDMGO !== 1'b0) begin n_err++; $display("FAIL reset_tdmgo: got %b want 0", TDMGO); end
      n_cmp++; if (dma_tenure !== 1'b0) begin n_err++; $display("FAIL reset_tenure: got %b want 0", dma_tenure); end
      n_cmp++; if (timeout_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %b want 0", timeout_pulse); end
      n_cmp++; if (grant_count !== 16'h0) begin n_err++; $display("FAIL reset_gcnt: got %h want 0000", grant_count); end
      n_cmp++; if (timeout_count !== 16'h0) begin n_err++; $display("FAIL reset_tcnt: got %h want 0000", timeout_count); end
      reset_L = 1'b1;
      tick(1);
      $display("test_reset done");
   endtask

   task automatic test_basic_grant;
      RDMR = 1'b1;
      tick(2);
      n_cmp++; if (TDMGO !== 1'b0) begin n_err++; $display("FAIL basic_early: got %b want 0", TDMGO); end
      tick(1);
      n_cmp++; if (TDMGO !== 1'b1) begin n_err++; $display("FAIL basic_grant: got %b want 1", TDMGO); end
      n_cmp++; if (dma_tenure !== 1'b1) begin n_err++; $display("FAIL basic_tenure: got %b want 1", dma_tenure); end
      tick(4);
      RSACK = 1'b1; RDMR = 1'b0;
      tick(2);
      n_cmp++; if (TDMGO !== 1'b1) begin n_err++; $display("FAIL basic_hold: got %b want 1", TDMGO); end
      tick(1);
      n_cmp++; if (TDMGO !== 1'b0) begin n_err++; $display("FAIL basic_sack_drop: got %b want 0", TDMGO); end
      n_cmp++; if (grant_count !== 16'd1) begin n_err++; $display("FAIL basic_gcnt: got %0d want 1", grant_count); end
      n_cmp++; if (dma_tenure !== 1'b1) begin n_err++; $display("FAIL basic_master: got %b want 1", dma_tenure); end
      tick(10);
      RSACK = 1'b0;
      tick(2);
      n_cmp++; if (dma_tenure !== 1'b1) begin n_err++; $display("FAIL basic_tenure_hold: got %b want 1", dma_tenure); end
      tick(1);
      n_cmp++; if (dma_tenure !== 1'b0) begin n_err++; $display("FAIL basic_tenure_end: got %b want 0", dma_tenure); end
      tick(3);
      n_cmp++; if (dut.state_reg !== ARB_GAP) begin n_err++; $display("FAIL basic_gap: got %0d want %0d", dut.state_reg, ARB_GAP); end
      tick(1);
      n_cmp++; if (dut.state_reg !== ARB_IDLE) begin n_err++; $display("FAIL basic_idle: got %0d want %0d", dut.state_reg, ARB_IDLE); end
      $display("test_basic_grant done");
   endtask

   task automatic test_timeout;
      int high_cnt;
      int pulse_cnt;
      RDMR = 1'b1;
      tick(3);
      high_cnt = (TDMGO === 1'b1) ? 1 : 0;
      pulse_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         tick(1);
         if (timeout_pulse === 1'b1) pulse_cnt++;
         if (TDMGO === 1'b1) high_cnt++;
         else break;
      end
      n_cmp++; if (high_cnt !== 200) begin n_err++; $display("FAIL timeout_len: got %0d want 200", high_cnt); end
      n_cmp++; if (pulse_cnt !== 1) begin n_err++; $display("FAIL timeout_pulse_at_fall: got %0d want 1", pulse_cnt); end
      n_cmp++; if (timeout_count !== 16'd1) begin n_err++; $display("FAIL timeout_tcnt: got %0d want 1", timeout_count); end
      tick(1);
      n_cmp++; if (timeout_pulse !== 1'b0) begin n_err++; $display("FAIL timeout_pulse_width: got %b want 0", timeout_pulse); end
      tick(3);
      n_cmp++; if (TDMGO !== 1'b0) begin n_err++; $display("FAIL timeout_gap: got %b want 0", TDMGO); end
      tick(1);
      n_cmp++; if (TDMGO !== 1'b1) begin n_err++; $display("FAIL timeout_regrant: got %b want 1", TDMGO); end
      RSACK = 1'b1;
      tick(3);
      n_cmp++; if (grant_count !== 16'd2) begin n_err++; $display("FAIL timeout_gcnt: got %0d want 2", grant_count); end
      RDMR = 1'b0; RSACK = 1'b0;
      tick(10);
      $display("test_timeout done");
   endtask

   task automatic test_cpu_busy;
      cpu_busy = 1'b1; RDMR = 1'b1;
      tick(6);
      n_cmp++; if (TDMGO !== 1'b0) begin n_err++; $display("FAIL cpu_block: got %b want 0", TDMGO); end
      cpu_busy = 1'b0;
      tick(1);
      n_cmp++; if (TDMGO !== 1'b1) begin n_err++; $display("FAIL cpu_release: got %b want 1", TDMGO); end
      cpu_busy = 1'b1;
      tick(2);
      n_cmp++; if (TDMGO !== 1'b1) begin n_err++; $display("FAIL cpu_in_grant: got %b want 1", TDMGO); end
      RSACK = 1'b1;
      tick(3);
      n_cmp++; if (dma_tenure !== 1'b1) begin n_err++; $display("FAIL cpu_in_master: got %b want 1", dma_tenure); end
      n_cmp++; if (grant_count !== 16'd3) begin n_err++; $display("FAIL cpu_gcnt: got %0d want 3", grant_count); end
      RDMR = 1'b0; RSACK = 1'b0; cpu_busy = 1'b0;
      tick(10);
      $display("test_cpu_busy done");
   endtask

   task automatic test_race;
      RDMR = 1'b1;
      tick(3);
      tick(197);
      RSACK = 1'b1;
      tick(2);
      n_cmp++; if (TDMGO !== 1'b1) begin n_err++; $display("FAIL race_pre: got %b want 1", TDMGO); end
      tick(1);
      n_cmp++; if (TDMGO !== 1'b0) begin n_err++; $display("FAIL race_tdmgo: got %b want 0", TDMGO); end
      n_cmp++; if (dma_tenure !== 1'b1) begin n_err++; $display("FAIL race_master: got %b want 1", dma_tenure); end
      n_cmp++; if (timeout_pulse !== 1'b0) begin n_err++; $display("FAIL race_pulse: got %b want 0", timeout_pulse); end
      n_cmp++; if (timeout_count !== 16'd1) begin n_err++; $display("FAIL race_tcnt: got %0d want 1", timeout_count); end
      n_cmp++; if (grant_count !== 16'd4) begin n_err++; $display("FAIL race_gcnt: got %0d want 4", grant_count); end
      RDMR = 1'b0;
      $display("test_race done");
   endtask

   task automatic test_reset_mid_tenure;
      RINIT = 1'b1;
      tick(3);
      n_cmp++; if (dut.state_reg !== ARB_IDLE) begin n_err++; $display("FAIL init_idle: got %0d want %0d", dut.state_reg, ARB_IDLE); end
      n_cmp++; if (dma_tenure !== 1'b0) begin n_err++; $display("FAIL init_tenure: got %b want 0", dma_tenure); end
      n_cmp++; if (grant_count !== 16'd0) begin n_err++; $display("FAIL init_gcnt: got %0d want 0", grant_count); end
      n_cmp++; if (timeout_count !== 16'd0) begin n_err++; $display("FAIL init_tcnt: got %0d want 0", timeout_count); end
      RINIT = 1'b0; RSACK = 1'b0;
      tick(6);
      RDMR = 1'b1;
      tick(3);
      n_cmp++; if (TDMGO !== 1'b1) begin n_err++; $display("FAIL rst_setup_grant: got %b want 1", TDMGO); end
      RSACK = 1'b1; RDMR = 1'b0;
      tick(3);
      n_cmp++; if (grant_count !== 16'd1) begin n_err++; $display("FAIL rst_setup_gcnt: got %0d want 1", grant_count); end
      reset_L = 1'b0;
      tick(1);
      n_cmp++; if (dut.state_reg !== ARB_IDLE) begin n_err++; $display("FAIL rstl_idle: got %0d want %0d", dut.state_reg, ARB_IDLE); end
      n_cmp++; if (grant_count !== 16'd0) begin n_err++; $display("FAIL rstl_gcnt: got %0d want 0", grant_count); end
      reset_L = 1'b1; RSACK = 1'b0; RDMR = 1'b1;
      tick(3);
      n_cmp++; if (TDMGO !== 1'b1) begin n_err++; $display("FAIL rstl_regrant: got %b want 1", TDMGO); end
      reset_L = 1'b0;
      tick(1);
      n_cmp++; if (TDMGO !== 1'b0) begin n_err++; $display("FAIL rstl_grant_drop: got %b want 0", TDMGO); end
      n_cmp++; if (timeout_pulse !== 1'b0) begin n_err++; $display("FAIL rstl_no_pulse: got %b want 0", timeout_pulse); end
      reset_L = 1'b1; RDMR = 1'b0;
      tick(3);
      $display("test_reset_mid_tenure done");
   endtask

   task automatic test_counter_wrap;
      force dut.grant_count_reg = 16'hFFFF;
      #1;
      release dut.grant_count_reg;
      #1;
      n_cmp++; if (grant_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffff", grant_count); end
      RDMR = 1'b1;
      tick(3);
      RSACK = 1'b1; RDMR = 1'b0;
      tick(3);
      n_cmp++; if (grant_count !== 16'h0000) begin n_err++; $display("FAIL wrap_gcnt: got %h want 0000", grant_count); end
      n_cmp++; if (dma_tenure !== 1'b1) begin n_err++; $display("FAIL wrap_master: got %b want 1", dma_tenure); end
      RSACK = 1'b0;
      tick(10);
      $display("test_counter_wrap done");
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_basic_grant;
      test_timeout;
      test_cpu_busy;
      test_race;
      test_reset_mid_tenure;
      test_counter_wrap;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
